// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit (AND/OR/XOR/ANDN) with per-stage valid/ready
// flow control; empty stages collapse so items advance even when the output stalls.
module logic_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_c,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] result;
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] data_reg [DEPTH];
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [DEPTH:0]   ready;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;

    always_comb begin
        case (in_op)
            2'b00:   result = in_a & in_b;
            2'b01:   result = in_a | in_b;
            2'b10:   result = in_a ^ in_b;
            default: result = in_a & ~in_b;
        endcase
    end

    // Each stage loads from its upstream neighbour; stage 0 loads the fresh result.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_src
            if (gi == 0) begin : g_head
                assign src_valid[gi] = in_valid;
                assign src_data[gi]  = result;
            end else begin : g_body
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_data[gi]  = data_reg[gi-1];
            end
        end
    endgenerate

    // A stage may load when it is empty or when everything downstream can move.
    always_comb begin
        ready      = '0;
        valid_next = '0;
        occ_next   = '0;
        ready[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready[i] = !valid_reg[i] | ready[i+1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            valid_next[i] = ready[i] ? src_valid[i] : valid_reg[i];
            occ_next      = occ_next + OCC_W'(valid_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            occ_reg   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            occ_reg   <= occ_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (ready[i]) begin
                    data_reg[i] <= src_data[i];
                end
            end
        end
    end

    assign in_ready  = ready[0] & ~rst;
    assign out_valid = valid_reg[DEPTH-1];
    assign out_c     = data_reg[DEPTH-1];
    assign occupancy = occ_reg;

endmodule

// File: tb/tb_logic_pipe.sv
// Bench for logic_pipe: directed phases plus a randomized scoreboard run against
// a queue-based reference; a second DEPTH=1 instance covers the single-register build.
module tb_logic_pipe;

    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'b00;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_c;
    logic [1:0]   occupancy;

    logic         v1 = 1'b0;
    logic         in_ready1;
    logic         out_valid1;
    logic         ordy1 = 1'b0;
    logic [W-1:0] out_c1;
    logic [0:0]   occupancy1;

    always #5 clk = ~clk;

    logic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_c(out_c), .occupancy(occupancy)
    );

    logic_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(in_ready1),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid1),
        .out_ready(ordy1), .out_c(out_c1), .occupancy(occupancy1)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           occ_m = 0;
    int           n_acc = 0;
    int           peak = 0;
    logic         chk_lat = 1'b0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_c = '0;
    logic [W-1:0] exp_q [$];
    int           stamp_q [$];
    logic [W-1:0] emitted [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    // One clock: drive, check against the reference, record handshakes, advance.
    task automatic cycle(input logic r, input logic v, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
        logic acc, emit, exp_rdy;
        rst = r; in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy;
        #1;
        exp_rdy = r ? 1'b0 : ((occ_m < D) || ordy);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("occupancy", {30'd0, occupancy}, occ_m);
        if (int'(occupancy) > peak) peak = int'(occupancy);
        if (prev_hold) begin
            chk("hold_valid", {31'd0, out_valid}, 1);
            chk("hold_data", {24'd0, out_c}, {24'd0, prev_c});
        end
        acc  = v & in_ready & ~r;
        emit = out_valid & ordy & ~r;
        prev_hold = out_valid & ~ordy & ~r;
        prev_c    = out_c;
        if (out_valid && exp_q.size() == 0) begin
            chk("unexpected_valid", {31'd0, out_valid}, 0);
        end
        if (emit && exp_q.size() != 0) begin
            chk("out_c", {24'd0, out_c}, {24'd0, exp_q[0]});
            if (chk_lat) chk("latency", cyc - stamp_q[0], D);
            $display("cyc %0d emit  c=%02h expect=%02h", cyc, out_c, exp_q[0]);
            emitted.push_back(out_c);
            void'(exp_q.pop_front());
            void'(stamp_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back(ref_op(op, a, b));
            stamp_q.push_back(cyc);
            n_acc++;
            $display("cyc %0d accept op=%0d a=%02h b=%02h", cyc, op, a, b);
        end
        occ_m = occ_m + int'(acc) - int'(emit);
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            exp_q.delete();
            stamp_q.delete();
            occ_m = 0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (exp_q.size() != 0 || occ_m != 0); k++) begin
            cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b1);
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_valid", {31'd0, out_valid}, 0);
    endtask

    initial begin
        logic [W-1:0] exp1;

        // Reset with in_valid held high
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_c", {24'd0, out_c}, 0);
        chk("rst_occ", {30'd0, occupancy}, 0);
        chk("rst_in_ready2", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);

        // All ops streaming
        emitted.delete();
        chk_lat = 1'b1;
        peak = 0;
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 2'(k), 8'hF0, 8'h3C, 1'b1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b1);
        chk_lat = 1'b0;
        chk("stream_count", emitted.size(), 4);
        if (emitted.size() == 4) begin
            chk("stream_and", {24'd0, emitted[0]}, 32'h30);
            chk("stream_or", {24'd0, emitted[1]}, 32'hFC);
            chk("stream_xor", {24'd0, emitted[2]}, 32'hCC);
            chk("stream_andn", {24'd0, emitted[3]}, 32'hC0);
        end
        chk("stream_peak", peak, 3);
        drain();

        // Back-pressure then release and refill
        n_acc = 0;
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 2'(k), 8'(k * 37), 8'(k * 11 + 5), 1'b0);
        chk("bp_accepts", n_acc, 3);
        chk("bp_occ", {30'd0, occupancy}, 3);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 2'(k), 8'(k * 13), 8'(~k), 1'b1);
        drain();

        // Randomized scoreboard run
        n_acc = 0;
        for (int k = 0; k < 2000 && n_acc < 100; k++) begin
            cycle(1'b0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        chk("rand_accepts", n_acc, 100);
        drain();

        // Bubble collapse: Y enters and advances while X is held at the output
        cycle(1'b0, 1'b1, 2'd0, 8'hAA, 8'h0F, 1'b0);
        cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b0);
        chk("bubble_x_at_out", {31'd0, out_valid}, 1);
        cycle(1'b0, 1'b1, 2'd1, 8'h50, 8'h05, 1'b0);
        cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b0);
        chk("bubble_occ", {30'd0, occupancy}, 2);
        cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b1);
        chk("bubble_y_valid", {31'd0, out_valid}, 1);
        chk("bubble_y_data", {24'd0, out_c}, 32'h55);
        drain();

        // Reset mid-operation, with a simultaneous handshake offered
        cycle(1'b0, 1'b1, 2'd2, 8'h12, 8'h34, 1'b0);
        cycle(1'b0, 1'b1, 2'd1, 8'h56, 8'h78, 1'b0);
        cycle(1'b1, 1'b1, 2'd0, 8'hFF, 8'hFF, 1'b1);
        chk("midrst_occ", {30'd0, occupancy}, 0);
        chk("midrst_valid", {31'd0, out_valid}, 0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 2'd0, '0, '0, 1'b1);

        // DEPTH=1 build: one-cycle latency, one result per cycle, occupancy stays 1
        in_valid = 1'b0; out_ready = 1'b1;
        ordy1 = 1'b1;
        exp1 = '0;
        for (int k = 0; k < 6; k++) begin
            v1 = 1'b1; in_op = 2'($urandom_range(0, 3)); in_a = 8'($urandom); in_b = 8'($urandom);
            #1;
            chk("d1_in_ready", {31'd0, in_ready1}, 1);
            if (k > 0) begin
                chk("d1_valid", {31'd0, out_valid1}, 1);
                chk("d1_data", {24'd0, out_c1}, {24'd0, exp1});
                chk("d1_occ", {31'd0, occupancy1}, 1);
                $display("cyc %0d d1 emit c=%02h expect=%02h", cyc, out_c1, exp1);
            end
            exp1 = ref_op(in_op, in_a, in_b);
            @(posedge clk); #1;
            cyc++;
        end
        v1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
